// File: rtl/dht_uart_formatter_pkg.sv
// Shared types and constants for the DHT11-to-UART line formatter.
// Holds the FSM state enum, message lengths and ASCII byte values.
package dht_uart_formatter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      LOAD,
      WAIT_HI,
      WAIT_LO
   } state_t;

   localparam int MSG_LEN = 13;
   localparam int ERR_LEN = 5;

   localparam logic [7:0] ASC_0    = 8'h30;
   localparam logic [7:0] ASC_H    = 8'h48;
   localparam logic [7:0] ASC_EQ   = 8'h3D;
   localparam logic [7:0] ASC_PCT  = 8'h25;
   localparam logic [7:0] ASC_SP   = 8'h20;
   localparam logic [7:0] ASC_T    = 8'h54;
   localparam logic [7:0] ASC_C    = 8'h43;
   localparam logic [7:0] ASC_CR   = 8'h0D;
   localparam logic [7:0] ASC_LF   = 8'h0A;
   localparam logic [7:0] ASC_E    = 8'h45;
   localparam logic [7:0] ASC_R    = 8'h52;
   localparam logic [7:0] ASC_DASH = 8'h2D;

   // A clamped (>=100) field prints as "--".
   function automatic logic [7:0] dig_char(
      input logic       ovf,
      input logic [3:0] d
   );
      return ovf ? ASC_DASH : (ASC_0 + {4'h0, d});
   endfunction

endpackage

// File: rtl/dht_bin2dec.sv
// Sequential binary-to-decimal converter using repeated subtraction of 10.
// Ports: clk, reset_n (async, active-low), start_i loads value_i and clears
// tens; done_o when ones < 10 or tens clamped at 10 (ovf_o); tens_o/ones_o.
module dht_bin2dec (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start_i,
   input  logic [7:0] value_i,
   output logic       done_o,
   output logic       ovf_o,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   logic [7:0] rem_q, rem_d;
   logic [3:0] tens_q, tens_d;

   assign ovf_o  = (tens_q == 4'd10);
   assign done_o = (rem_q < 8'd10) || ovf_o;
   assign tens_o = tens_q;
   assign ones_o = rem_q[3:0];

   // Steps only while not done; idle after reset since rem is 0.
   always_comb begin
      rem_d  = rem_q;
      tens_d = tens_q;
      if (start_i) begin
         rem_d  = value_i;
         tens_d = 4'd0;
      end else if (!done_o) begin
         rem_d  = rem_q - 8'd10;
         tens_d = tens_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q  <= 8'd0;
         tens_q <= 4'd0;
      end else begin
         rem_q  <= rem_d;
         tens_q <= tens_d;
      end
   end

endmodule

// File: rtl/dht_uart_formatter.sv
// Turns each DHT11 reading into "H=hh% T=ttC\r\n" (or "ERR\r\n") and feeds
// it byte by byte to an 8N1 UART transmitter via tx_data/tx_send/tx_busy.
// Ports: clk, reset_n (async, active-low); sample_valid/humidity/
// temperature/sample_err from the sampler; ready (high in IDLE);
// tx_data/tx_send/tx_busy to the transmitter; msg_done/msg_abort pulses;
// drop_cnt saturating count of readings ignored while busy.
module dht_uart_formatter
   import dht_uart_formatter_pkg::*;
#(
   parameter int BUSY_TIMEOUT = 15,
   parameter int CNT_W        = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sample_valid,
   input  logic [7:0] humidity,
   input  logic [7:0] temperature,
   input  logic       sample_err,
   output logic       ready,
   output logic [7:0] tx_data,
   output logic       tx_send,
   input  logic       tx_busy,
   output logic       msg_done,
   output logic       msg_abort,
   output logic [7:0] drop_cnt
);

   localparam logic [CNT_W-1:0] TMO      = CNT_W'(BUSY_TIMEOUT);
   localparam logic [3:0]       MSG_LAST = 4'(MSG_LEN - 1);
   localparam logic [3:0]       ERR_LAST = 4'(ERR_LEN - 1);

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_send_q, tx_send_d;
   logic             done_q, done_d;
   logic             abort_q, abort_d;
   logic [7:0]       drop_q, drop_d;

   logic       conv_start;
   logic       h_done, h_ovf, t_done, t_ovf;
   logic [3:0] h_tens, h_ones, t_tens, t_ones;
   logic [7:0] cur_byte;
   logic [3:0] last_idx;

   dht_bin2dec u_hum (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (conv_start),
      .value_i (humidity),
      .done_o  (h_done),
      .ovf_o   (h_ovf),
      .tens_o  (h_tens),
      .ones_o  (h_ones)
   );

   dht_bin2dec u_tmp (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (conv_start),
      .value_i (temperature),
      .done_o  (t_done),
      .ovf_o   (t_ovf),
      .tens_o  (t_tens),
      .ones_o  (t_ones)
   );

   assign last_idx = err_q ? ERR_LAST : MSG_LAST;

   always_comb begin
      cur_byte = ASC_LF;
      if (err_q) begin
         case (idx_q)
            4'd0:    cur_byte = ASC_E;
            4'd1:    cur_byte = ASC_R;
            4'd2:    cur_byte = ASC_R;
            4'd3:    cur_byte = ASC_CR;
            default: cur_byte = ASC_LF;
         endcase
      end else begin
         case (idx_q)
            4'd0:    cur_byte = ASC_H;
            4'd1:    cur_byte = ASC_EQ;
            4'd2:    cur_byte = dig_char(h_ovf, h_tens);
            4'd3:    cur_byte = dig_char(h_ovf, h_ones);
            4'd4:    cur_byte = ASC_PCT;
            4'd5:    cur_byte = ASC_SP;
            4'd6:    cur_byte = ASC_T;
            4'd7:    cur_byte = ASC_EQ;
            4'd8:    cur_byte = dig_char(t_ovf, t_tens);
            4'd9:    cur_byte = dig_char(t_ovf, t_ones);
            4'd10:   cur_byte = ASC_C;
            4'd11:   cur_byte = ASC_CR;
            default: cur_byte = ASC_LF;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_send_d  = 1'b0;
      done_d     = 1'b0;
      abort_d    = 1'b0;
      drop_d     = drop_q;
      conv_start = 1'b0;

      // Any reading outside IDLE is dropped, including the return cycle.
      if (sample_valid && (state_q != IDLE) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (sample_valid) begin
               idx_d = 4'd0;
               err_d = sample_err;
               if (sample_err) begin
                  state_d = LOAD;
               end else begin
                  conv_start = 1'b1;
                  state_d    = CONV;
               end
            end
         end
         CONV: begin
            if (h_done && t_done) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (!tx_busy) begin
               tx_data_d = cur_byte;
               tx_send_d = 1'b1;
               cnt_d     = '0;
               state_d   = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy) begin
               state_d = WAIT_LO;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == TMO) begin
                  abort_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               if (idx_q == last_idx) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= 4'd0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         tx_data_q <= 8'h00;
         tx_send_q <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         drop_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         tx_data_q <= tx_data_d;
         tx_send_q <= tx_send_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
         drop_q    <= drop_d;
      end
   end

   assign ready     = ready_q;
   assign tx_data   = tx_data_q;
   assign tx_send   = tx_send_q;
   assign msg_done  = done_q;
   assign msg_abort = abort_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_dht_uart_formatter.sv
// Self-checking bench for dht_uart_formatter with a serial UART model
// (shortened bit time) and a line receiver that decodes the output.
module tb_dht_uart_formatter;

   localparam int BIT = 4;
   localparam int TMO = 15;

   typedef struct {
      int    h;
      int    t;
      bit    e;
      int    conv;
      string txt;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] humidity = 8'd0;
   logic [7:0] temperature = 8'd0;
   logic       sample_err = 1'b0;
   logic       ready;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       tx_busy;
   logic       msg_done;
   logic       msg_abort;
   logic [7:0] drop_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] sent[$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int n_done, n_abort, t_fall, t_send, t_abort;
   logic rdy_prev = 1'b1;
   bit   tx_en = 1'b1;
   logic line;
   logic [9:0] fr;
   logic [7:0] rb;
   vec_t vecs[7];

   dht_uart_formatter #(.BUSY_TIMEOUT(TMO), .CNT_W(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .humidity     (humidity),
      .temperature  (temperature),
      .sample_err   (sample_err),
      .ready        (ready),
      .tx_data      (tx_data),
      .tx_send      (tx_send),
      .tx_busy      (tx_busy),
      .msg_done     (msg_done),
      .msg_abort    (msg_abort),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // UART transmitter: 8N1, BIT clocks per bit, LSB first.
   initial begin
      tx_busy = 1'b0;
      line    = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_en && tx_send) begin
            fr      = {1'b1, tx_data, 1'b0};
            tx_busy = 1'b1;
            for (int i = 0; i < 10; i++) begin
               line = fr[i];
               repeat (BIT) @(negedge clk);
            end
            tx_busy = 1'b0;
         end
      end
   end

   // Line receiver, mid-bit sampling.
   initial forever begin
      @(posedge clk);
      if (line == 1'b0) begin
         repeat (BIT / 2) @(posedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(posedge clk);
            rb[i] = line;
         end
         repeat (BIT) @(posedge clk);
         rx_q.push_back(rb);
      end
   end

   initial forever begin
      @(negedge clk);
      if (tx_send) begin
         if (sent.size() == 0) t_send = cyc;
         sent.push_back(tx_data);
      end
      if (msg_done) n_done++;
      if (msg_abort) begin
         n_abort++;
         t_abort = cyc;
      end
      if (rdy_prev && !ready) t_fall = cyc;
      rdy_prev = ready;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   task automatic clear_mon();
      sent.delete();
      rx_q.delete();
      n_done  = 0;
      n_abort = 0;
      t_fall  = -1;
      t_send  = -1;
      t_abort = -1;
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   task automatic set_exp_txt(input string s);
      exp_q.delete();
      push_str(s);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   function automatic int tens_of(input int v);
      return (v / 10 > 10) ? 10 : v / 10;
   endfunction

   task automatic push_dig(input int v);
      if (v >= 100) begin
         push_str("--");
      end else begin
         exp_q.push_back(8'(48 + v / 10));
         exp_q.push_back(8'(48 + v % 10));
      end
   endtask

   // Reference: the line text and the number of conversion cycles.
   task automatic model(input int h, input int t, input bit e,
                        output int conv);
      exp_q.delete();
      if (e) begin
         push_str("ERR");
         conv = 0;
      end else begin
         push_str("H=");
         push_dig(h);
         push_str("% T=");
         push_dig(t);
         push_str("C");
         conv = ((tens_of(h) > tens_of(t)) ? tens_of(h) : tens_of(t)) + 1;
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic send_reading(input int h, input int t, input bit e);
      @(negedge clk);
      humidity     = 8'(h);
      temperature  = 8'(t);
      sample_err   = e;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_end(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (n_done + n_abort > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_msg(input int h, input int t, input bit e,
                          input int conv, input string tag);
      bit ok;
      clear_mon();
      send_reading(h, t, e);
      wait_end(4000, ok);
      chk({tag, " finished"}, int'(ok), 1);
      chk({tag, " done"}, n_done, 1);
      chk({tag, " abort"}, n_abort, 0);
      chk({tag, " nsend"}, sent.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("%s tx%0d", tag, i),
             (i < sent.size()) ? int'(sent[i]) : -1, int'(exp_q[i]));
         chk($sformatf("%s rx%0d", tag, i),
             (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(exp_q[i]));
      end
      chk({tag, " conv"}, t_send - t_fall, conv + 1);
      chk({tag, " ready"}, int'(ready), 1);
   endtask

   task automatic pulse_during(input int n_after, input int count,
                               input int gap);
      int k = 0;
      while (sent.size() < n_after && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk("drop window", int'(sent.size() >= n_after), 1);
      for (int i = 0; i < count; i++) begin
         @(negedge clk);
         sample_valid = 1'b1;
         humidity     = 8'($urandom);
         temperature  = 8'($urandom);
         sample_err   = 1'($urandom);
         repeat (gap) begin
            @(negedge clk);
            sample_valid = 1'b0;
         end
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   initial begin
      bit ok;
      int k;
      int c;
      int h;
      int t;
      bit e;

      vecs[0] = '{45, 23, 1'b0, 5, "H=45% T=23C"};
      vecs[1] = '{0, 0, 1'b1, 0, "ERR"};
      vecs[2] = '{120, 0, 1'b0, 11, "H=--% T=00C"};
      vecs[3] = '{0, 0, 1'b0, 1, "H=00% T=00C"};
      vecs[4] = '{99, 9, 1'b0, 10, "H=99% T=09C"};
      vecs[5] = '{100, 255, 1'b0, 11, "H=--% T=--C"};
      vecs[6] = '{9, 10, 1'b0, 2, "H=09% T=10C"};

      clear_mon();
      #12;
      chk("rst ready", int'(ready), 1);
      chk("rst tx_data", int'(tx_data), 0);
      chk("rst tx_send", int'(tx_send), 0);
      chk("rst done", int'(msg_done), 0);
      chk("rst abort", int'(msg_abort), 0);
      chk("rst drop", int'(drop_cnt), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         set_exp_txt(vecs[i].txt);
         run_msg(vecs[i].h, vecs[i].t, vecs[i].e, vecs[i].conv,
                 $sformatf("vec%0d", i));
         repeat (3) @(negedge clk);
      end
      chk("drop none", int'(drop_cnt), 0);

      set_exp_txt("H=45% T=23C");
      fork
         run_msg(45, 23, 1'b0, 5, "drop3");
         pulse_during(2, 3, 10);
      join
      chk("drop3 cnt", int'(drop_cnt), 3);
      repeat (3) @(negedge clk);

      set_exp_txt("H=07% T=81C");
      fork
         run_msg(7, 81, 1'b0, 9, "drop260");
         pulse_during(1, 260, 0);
      join
      chk("drop sat", int'(drop_cnt), 255);
      repeat (3) @(negedge clk);

      tx_en = 1'b0;
      clear_mon();
      send_reading(45, 23, 1'b0);
      wait_end(500, ok);
      chk("abort seen", int'(ok), 1);
      chk("abort cnt", n_abort, 1);
      chk("abort nodone", n_done, 0);
      chk("abort delay", t_abort - t_send, TMO);
      chk("abort ready", int'(ready), 1);
      repeat (20) @(negedge clk);
      chk("abort nsend", sent.size(), 1);
      chk("abort byte", (sent.size() > 0) ? int'(sent[0]) : -1, 8'h48);
      chk("abort rx", rx_q.size(), 0);
      tx_en = 1'b1;

      for (int r = 0; r < 20; r++) begin
         h = (r % 2 == 0) ? int'($urandom_range(0, 255))
                          : int'($urandom_range(0, 110));
         t = int'($urandom_range(0, 127));
         e = ($urandom_range(0, 5) == 0);
         model(h, t, e, c);
         run_msg(h, t, e, c, $sformatf("rnd%0d h%0d t%0d e%0d", r, h, t, e));
         repeat (2) @(negedge clk);
      end

      clear_mon();
      send_reading(45, 23, 1'b0);
      k = 0;
      while (sent.size() < 6 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("rst6 reached", int'(sent.size() >= 6), 1);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid rst ready", int'(ready), 1);
      chk("mid rst tx_data", int'(tx_data), 0);
      chk("mid rst tx_send", int'(tx_send), 0);
      chk("mid rst done", int'(msg_done), 0);
      chk("mid rst abort", int'(msg_abort), 0);
      chk("mid rst drop", int'(drop_cnt), 0);
      @(negedge clk);
      reset_n = 1'b1;
      k = 0;
      while (tx_busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("rst tx idle", int'(tx_busy), 0);
      repeat (8) @(negedge clk);
      chk("rst no done", n_done, 0);
      chk("rst no abort", n_abort, 0);
      chk("rst nsend", sent.size(), 6);

      set_exp_txt("H=45% T=23C");
      run_msg(45, 23, 1'b0, 5, "post-rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dht_uart_formatter.md
Name: dht_uart_formatter

Overview:
- Sequences the 8N1 UART transmitter, which has a data/send/busy handshake: it turns each DHT11 reading into an ASCII line and feeds it to the transmitter one byte at a time.
- Sits between the DHT11 sampler (upstream) and the UART transmitter (downstream).
- Normal line: "H=hh% T=ttC\r\n" (13 bytes). Checksum-fail line: "ERR\r\n" (5 bytes).
- Binary-to-decimal conversion is done sequentially, by repeated subtraction.

Parameters:
- BUSY_TIMEOUT, 15: cycles allowed in WAIT_HI for tx_busy to rise before the message is aborted.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > BUSY_TIMEOUT.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- sample_valid  input  1  single-cycle strobe; new reading present
- humidity  input  8  integer humidity, binary
- temperature  input  8  integer temperature, binary
- sample_err  input  1  qualifies sample_valid; 1 = checksum failure
- ready  output  1  high only in IDLE
- tx_data  output  8  byte to the transmitter
- tx_send  output  1  single-cycle send request to the transmitter
- tx_busy  input  1  transmitter busy flag
- msg_done  output  1  single-cycle pulse when the final byte has completed
- msg_abort  output  1  single-cycle pulse on busy timeout
- drop_cnt  output  8  saturating count of readings ignored while not ready

Behaviour:
- Reset values (asynchronous): state=IDLE, ready=1, tx_data=8'h00, tx_send=0, msg_done=0, msg_abort=0, drop_cnt=0, all internal registers 0.
- All outputs are registered.

States and transitions:
- IDLE:
  - On sample_valid with sample_err=0: latch humidity and temperature into rem registers, clear tens registers, go to CONV.
  - On sample_valid with sample_err=1: select the ERR message, idx=0, go to LOAD.
  - ready falls the cycle after acceptance.
- CONV, one step per cycle:
  - If h_rem>=10: h_rem-=10 and h_tens++. Same rule for t_rem/t_tens, in parallel.
  - When both rems are <10, go to LOAD with idx=0.
  - Occupancy: max(h/10, t/10)+1 cycles, with the value clamped at 100 (see next item).
- Values >=100: the converter stops once tens reaches 10, and both digit bytes for that field are sent as '-' (8'h2D).
- LOAD:
  - Waits while tx_busy=1.
  - When tx_busy=0: tx_data <= byte[idx], tx_send <= 1 (high for exactly one cycle), clear the timeout counter, go to WAIT_HI.
- WAIT_HI:
  - On tx_busy=1: go to WAIT_LO.
  - Otherwise the counter increments. When it reaches BUSY_TIMEOUT: pulse msg_abort, go to IDLE, no further bytes sent.
- WAIT_LO:
  - On tx_busy=0: if idx is the last index, pulse msg_done and go to IDLE; else idx++ and go to LOAD.
- tx_data holds its value from LOAD until the next LOAD.

Byte maps:
- Normal message, idx 0..12: 'H','=',h_tens+8'h30,h_rem+8'h30,'%',' ','T','=',t_tens+8'h30,t_rem+8'h30,'C',8'h0D,8'h0A.
- ERR message, idx 0..4: 'E','R','R',8'h0D,8'h0A.
- idx is 4 bits.

Boundary conditions:
- sample_valid while not in IDLE: reading ignored, drop_cnt++ (saturates at 255). The in-flight message is unaffected.
- sample_valid in the same cycle the FSM returns to IDLE: counts as not ready, so it is dropped.
- Reset mid-message: immediate return to reset values. A byte already handed to the transmitter completes on its own. No msg_done or msg_abort is produced.
- A message is never interleaved with another message or truncated, except by abort or reset.

Decomposition:
- Shared package holds:
  - state enum: IDLE, CONV, LOAD, WAIT_HI, WAIT_LO
  - message-length constants: MSG_LEN=13, ERR_LEN=5
  - ASCII constants
- One sub-module, dht_bin2dec: sequential repeated-subtract converter with start, done, and tens/ones outputs. It is instantiated twice, once for humidity and once for temperature.
- Byte-map mux stays in the top level.

Test Plan:
- h=45, t=23, sample_err=0, with the real 12 MHz / 9600 transmitter model:
  - tx_data sequence 48 3D 34 35 25 20 54 3D 32 33 43 0D 0A
  - exactly 13 tx_send pulses
  - msg_done once
  - serial line decodes to "H=45% T=23C\r\n"
- sample_valid with sample_err=1 -> bytes 45 52 52 0D 0A, msg_done once, no CONV cycles.
- h=120, t=0:
  - humidity digits sent as 2D 2D, temperature digits as 30 30
  - CONV lasts 11 cycles
- Three extra sample_valid pulses during transmission -> drop_cnt=3, message bytes unchanged. Also drive 260 drops -> drop_cnt saturates at 255.
- tx_busy tied to 0:
  - single tx_send with tx_data=48
  - msg_abort exactly BUSY_TIMEOUT cycles after WAIT_HI entry
  - ready=1 afterward
- reset_n pulsed low during byte 6:
  - all outputs at reset values within the same cycle
  - next valid reading produces a complete, correct 13-byte message
